scan_req_ctrl: RTL and testbench

Scan-side request controller that sits directly upstream of the SRAM/control-register address mux. It synchronizes the slow external scan pins into the core clock domain and shifts a 45-bit command frame in. On a load strobe it issues one read or write on the scan bus and holds it until `scan_ready` or a timeout. Read data is captured and shifted back out on `scan_out`.

---
 rtl/scan_req_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_scan_req_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_req_ctrl.sv
// scan_req_ctrl: scan-pin front end that shifts in a command frame,
// issues one read/write to the address mux and shifts read data back out.
module scan_req_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        scan_clk_in,
   input  logic        scan_in,
   input  logic        scan_load,
   output logic        scan_out,
   output logic        scan_ren,
   output logic        scan_wen,
   output logic [10:0] scan_addr,
   output logic [31:0] scan_wdata,
   input  logic [31:0] scan_rdata,
   input  logic        scan_ready,
   output logic        busy,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [7:0]  TO_CNT   = TIMEOUT[7:0];
   localparam logic [31:0] ABORT_WD = 32'hDEAD_BEEF;

   // synchronizer chains, index 1 is the synced value
   logic [1:0] sclk_sync_q;
   logic [1:0] sin_sync_q;
   logic [1:0] sld_sync_q;
   logic       sclk_prev_q;
   logic       sld_prev_q;

   logic       shift_p;
   logic       load_p;
   logic       sin_s;

   state_e      state_q, state_d;
   logic [44:0] frm_q, frm_d;
   logic [31:0] oreg_q, oreg_d;
   logic        ren_q, ren_d;
   logic        wen_q, wen_d;
   logic [10:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        err_q, err_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        f_wr;
   logic        f_rd;
   logic [10:0] f_addr;
   logic [31:0] f_wdata;

   // two-flop synchronizers plus edge-detect history for the scan pins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= 2'b00;
         sin_sync_q  <= 2'b00;
         sld_sync_q  <= 2'b00;
         sclk_prev_q <= 1'b0;
         sld_prev_q  <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[0], scan_clk_in};
         sin_sync_q  <= {sin_sync_q[0], scan_in};
         sld_sync_q  <= {sld_sync_q[0], scan_load};
         sclk_prev_q <= sclk_sync_q[1];
         sld_prev_q  <= sld_sync_q[1];
      end
   end

   assign shift_p = sclk_sync_q[1] & ~sclk_prev_q;
   assign load_p  = sld_sync_q[1] & ~sld_prev_q;
   assign sin_s   = sin_sync_q[1];

   // command fields decoded from the registered frame
   assign f_wr    = frm_q[44];
   assign f_rd    = frm_q[43];
   assign f_addr  = frm_q[42:32];
   assign f_wdata = frm_q[31:0];

   // next-state logic: frame/readback shifting, command decode, request hold
   always_comb begin
      state_d = state_q;
      frm_d   = frm_q;
      oreg_d  = oreg_q;
      ren_d   = ren_q;
      wen_d   = wen_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         IDLE: begin
            cnt_d = 8'd0;
            if (shift_p) begin
               frm_d  = {frm_q[43:0], sin_s};
               oreg_d = {oreg_q[30:0], 1'b0};
            end
            if (load_p) begin
               unique case ({f_wr, f_rd})
                  2'b10: begin
                     addr_d  = f_addr;
                     wdata_d = f_wdata;
                     wen_d   = 1'b1;
                     cnt_d   = 8'd1;
                     state_d = REQ;
                  end
                  2'b01: begin
                     addr_d  = f_addr;
                     ren_d   = 1'b1;
                     cnt_d   = 8'd1;
                     state_d = REQ;
                  end
                  2'b11: begin
                     err_d = 1'b1;
                  end
                  default: begin
                  end
               endcase
            end
         end

         REQ: begin
            if (shift_p || load_p) begin
               err_d = 1'b1;
            end
            if (scan_ready) begin
               ren_d   = 1'b0;
               wen_d   = 1'b0;
               cnt_d   = 8'd0;
               state_d = DONE;
               if (ren_q) begin
                  oreg_d = scan_rdata;
               end
            end else if (cnt_q == TO_CNT) begin
               ren_d   = 1'b0;
               wen_d   = 1'b0;
               err_d   = 1'b1;
               oreg_d  = ABORT_WD;
               cnt_d   = 8'd0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         DONE: begin
            cnt_d = 8'd0;
            if (shift_p) begin
               frm_d  = {frm_q[43:0], sin_s};
               oreg_d = {oreg_q[30:0], 1'b0};
            end
            state_d = IDLE;
         end

         default: begin
            ren_d   = 1'b0;
            wen_d   = 1'b0;
            cnt_d   = 8'd0;
            state_d = IDLE;
         end
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         frm_q   <= '0;
         oreg_q  <= '0;
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         frm_q   <= frm_d;
         oreg_q  <= oreg_d;
         ren_q   <= ren_d;
         wen_q   <= wen_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign scan_out   = oreg_q[31];
   assign scan_ren   = ren_q;
   assign scan_wen   = wen_q;
   assign scan_addr  = addr_q;
   assign scan_wdata = wdata_q;
   assign busy       = (state_q == REQ);
   assign err        = err_q;

endmodule

// File: tb/tb_scan_req_ctrl.sv
// tb_scan_req_ctrl: scoreboard bench for scan_req_ctrl with a
// transaction-level model of requests, error flag and readback stream.
module tb_scan_req_ctrl;

   localparam int TO = 255;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        scan_clk_in = 1'b0;
   logic        scan_in = 1'b0;
   logic        scan_load = 1'b0;
   logic [31:0] scan_rdata = '0;
   logic        scan_ready = 1'b0;
   logic        scan_out;
   logic        scan_ren;
   logic        scan_wen;
   logic [10:0] scan_addr;
   logic [31:0] scan_wdata;
   logic        busy;
   logic        err;

   scan_req_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .scan_clk_in(scan_clk_in),
      .scan_in(scan_in),
      .scan_load(scan_load),
      .scan_out(scan_out),
      .scan_ren(scan_ren),
      .scan_wen(scan_wen),
      .scan_addr(scan_addr),
      .scan_wdata(scan_wdata),
      .scan_rdata(scan_rdata),
      .scan_ready(scan_ready),
      .busy(busy),
      .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [10:0] addr;
      logic [31:0] wdata;
      int          len;
   } req_t;

   int          checks = 0;
   int          errors = 0;
   req_t        exp_q[$];
   logic        exp_bits[$];
   int          resp_delay = 0;
   logic [31:0] resp_data = '0;
   logic [31:0] m_oreg = '0;
   logic        m_err = 1'b0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // mux responder: raises scan_ready in the resp_delay-th request cycle
   initial begin : responder
      int c;
      c = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            c = 0;
            scan_ready = 1'b0;
         end else if (scan_ren || scan_wen) begin
            c++;
            if (c == resp_delay) begin
               scan_ready = 1'b1;
               scan_rdata = resp_data;
            end
         end else begin
            c = 0;
            scan_ready = 1'b0;
            scan_rdata = $urandom;
         end
      end
   end

   // request monitor: pops an expected request on each new request
   initial begin : req_mon
      req_t e;
      bit   act;
      bit   have;
      int   len;
      act  = 0;
      have = 0;
      len  = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            act = 0;
         end else if (scan_ren || scan_wen) begin
            if (!act) begin
               act = 1;
               len = 0;
               if (exp_q.size() == 0) begin
                  have = 0;
                  checks++;
                  errors++;
                  $display("FAIL unexpected_req: got ren=%b wen=%b addr=%h required none",
                           scan_ren, scan_wen, scan_addr);
               end else begin
                  have = 1;
                  e = exp_q.pop_front();
                  chk("req_wen", {31'd0, scan_wen}, {31'd0, e.wr});
                  chk("req_ren", {31'd0, scan_ren}, {31'd0, ~e.wr});
               end
            end
            len++;
            if (have) begin
               chk("req_addr", {21'd0, scan_addr}, {21'd0, e.addr});
               if (e.wr) chk("req_wdata", scan_wdata, e.wdata);
               chk("req_busy", {31'd0, busy}, 32'd1);
            end
         end else if (act) begin
            act = 0;
            if (have) chk("req_len", len, e.len);
         end
      end
   end

   // readback monitor: one expected bit per scan clock rising edge
   initial begin : bit_mon
      forever begin
         @(posedge scan_clk_in);
         if (exp_bits.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scan_out_unexp: got %b required no shift", scan_out);
         end else begin
            chk("scan_out", {31'd0, scan_out}, {31'd0, exp_bits.pop_front()});
         end
      end
   end

   task automatic scan_bit(input logic b);
      exp_bits.push_back(m_oreg[31]);
      m_oreg = {m_oreg[30:0], 1'b0};
      scan_in = b;
      repeat (5) @(negedge clk);
      scan_clk_in = 1'b1;
      repeat (5) @(negedge clk);
      scan_clk_in = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic shift_frame(input logic wr, input logic rd,
                              input logic [10:0] a, input logic [31:0] wd);
      logic [44:0] f;
      f = {wr, rd, a, wd};
      for (int i = 44; i >= 0; i--) scan_bit(f[i]);
   endtask

   task automatic pulse_load();
      scan_load = 1'b1;
      repeat (6) @(negedge clk);
      scan_load = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 600; i++) begin
         if (!busy && !scan_ren && !scan_wen) break;
         @(negedge clk);
      end
      if (i == 600) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: busy=%b still set, required idle", busy);
      end
      repeat (3) @(negedge clk);
   endtask

   // model of one frame + load: request, length, error and readback word
   task automatic expect_cmd(input logic wr, input logic rd,
                             input logic [10:0] a, input logic [31:0] wd,
                             input int delay, input logic [31:0] rdata);
      req_t r;
      resp_delay = delay;
      resp_data  = rdata;
      if (wr && rd) begin
         m_err = 1'b1;
      end else if (wr || rd) begin
         r.wr    = wr;
         r.addr  = a;
         r.wdata = wd;
         if (delay == 0 || delay > TO) begin
            r.len  = TO;
            m_err  = 1'b1;
            m_oreg = 32'hDEAD_BEEF;
         end else begin
            r.len = delay;
            if (rd) m_oreg = rdata;
         end
         exp_q.push_back(r);
      end
   endtask

   task automatic transact(input logic wr, input logic rd,
                           input logic [10:0] a, input logic [31:0] wd,
                           input int delay, input logic [31:0] rdata);
      logic [31:0] pre;
      pre = m_oreg;
      shift_frame(wr, rd, a, wd);
      m_oreg = pre << 45;
      expect_cmd(wr, rd, a, wd, delay, rdata);
      pulse_load();
      wait_idle();
      chk("err", {31'd0, err}, {31'd0, m_err});
      chk("busy_idle", {31'd0, busy}, 32'd0);
   endtask

   task automatic reset_check(input string tag);
      rst_n = 1'b0;
      #1;
      chk({tag, "_scan_out"}, {31'd0, scan_out}, 32'd0);
      chk({tag, "_ren"}, {31'd0, scan_ren}, 32'd0);
      chk({tag, "_wen"}, {31'd0, scan_wen}, 32'd0);
      chk({tag, "_addr"}, {21'd0, scan_addr}, 32'd0);
      chk({tag, "_wdata"}, scan_wdata, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_err"}, {31'd0, err}, 32'd0);
      m_oreg = '0;
      m_err  = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      req_t r;
      int   k;
      #2;
      reset_check("rst0");

      // write path
      transact(1'b1, 1'b0, 11'h005, 32'hA5A5_1234, 3, 32'h0);
      // read path, ready after 4 cycles
      transact(1'b0, 1'b1, 11'h600, 32'h0, 4, 32'h0000_0400);
      // no-op frame shifts the read data out
      transact(1'b0, 1'b0, 11'h000, 32'h0, 1, 32'h0);

      // randomized legal traffic
      for (int n = 0; n < 12; n++) begin
         k = $urandom_range(0, 2);
         transact(k == 1, k == 2, 11'($urandom), $urandom,
                  $urandom_range(1, 12), $urandom);
      end

      // reset while a write is outstanding, then a clean write
      shift_frame(1'b1, 1'b0, 11'h123, 32'h0BAD_F00D);
      r.wr = 1'b1; r.addr = 11'h123; r.wdata = 32'h0BAD_F00D; r.len = 0;
      exp_q.push_back(r);
      resp_delay = 0;
      pulse_load();
      chk("mid_wen", {31'd0, scan_wen}, 32'd1);
      reset_check("rst_mid");
      transact(1'b1, 1'b0, 11'h0FF, 32'h1357_9BDF, 5, 32'h0);

      // illegal frame: no request, sticky error
      transact(1'b1, 1'b1, 11'h3AA, 32'h5555_AAAA, 2, 32'h0);
      reset_check("rst_ill");

      // read timeout, then DEADBEEF on readback
      transact(1'b0, 1'b1, 11'h010, 32'h0, 0, 32'h0);
      transact(1'b0, 1'b0, 11'h000, 32'h0, 1, 32'h0);
      reset_check("rst_to");

      // second load while request is pending
      shift_frame(1'b0, 1'b1, 11'h444, 32'h0);
      expect_cmd(1'b0, 1'b1, 11'h444, 32'h0, 40, 32'hC0DE_1234);
      pulse_load();
      pulse_load();
      m_err = 1'b1;
      wait_idle();
      chk("busy_load_err", {31'd0, err}, {31'd0, m_err});
      transact(1'b0, 1'b0, 11'h000, 32'h0, 1, 32'h0);

      chk("exp_q_empty", exp_q.size(), 32'd0);
      chk("exp_bits_empty", exp_bits.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
